// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters with a req/ack handshake.
// Define ARB_ANTISTARVE_EN to force a fetch grant after MAX_D_STREAK data grants.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_valid,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic                    stall_f,
  output logic                    stall_m
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StGntI, StGntD, StResp} state_e;

  state_e                  state_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [BeWidth-1:0]      mem_be_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;
  logic                    i_valid_q;
  logic                    d_valid_q;

  logic fetch_forced;
  logic grant_d;
  logic grant_i;

`ifdef ARB_ANTISTARVE_EN
  localparam int unsigned StreakWidth = $clog2(MAX_D_STREAK + 1);

  logic [StreakWidth-1:0] streak_q;

  assign fetch_forced = i_req && (streak_q == StreakWidth'(MAX_D_STREAK));

  // Counts data grants taken while fetch was waiting; never exceeds MAX_D_STREAK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else if (grant_i) begin
      streak_q <= '0;
    end else if (grant_d) begin
      streak_q <= i_req ? streak_q + StreakWidth'(1) : '0;
    end
  end
`else
  logic unused_streak_cfg;
  assign unused_streak_cfg = ^MAX_D_STREAK;
  assign fetch_forced      = 1'b0;
`endif

  assign grant_d = (state_q == StIdle) && d_req && !fetch_forced;
  assign grant_i = (state_q == StIdle) && !grant_d && i_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q     <= StGntD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_be_q    <= d_we ? d_be : '1;
          end else if (grant_i) begin
            state_q    <= StGntI;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr;
            mem_be_q   <= '1;
          end
        end
        StGntI: begin
          if (mem_ack) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            i_rdata_q <= mem_rdata;
            i_valid_q <= 1'b1;
          end
        end
        StGntD: begin
          if (mem_ack) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            d_valid_q <= 1'b1;
            if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end
        end
        StResp: begin
          // Requests present here are only considered once back in idle.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign stall_f   = i_req & ~i_valid_q;
  assign stall_m   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          stall_f;
  logic          stall_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_valid  (i_valid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_f  (stall_f),
    .stall_m  (stall_m)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, whether this is the response cycle.
  int            m_owner = 0;  // 0 none, 1 fetch, 2 data
  bit            m_resp  = 1'b0;
  bit            m_ival  = 1'b0;
  bit            m_dval  = 1'b0;
  logic [DW-1:0] m_irdata = '0;
  logic [DW-1:0] m_drdata = '0;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic [BW-1:0] m_be     = '0;
  int            m_streak = 0;

  task automatic model_reset();
    m_owner = 0; m_resp = 1'b0; m_ival = 1'b0; m_dval = 1'b0;
    m_irdata = '0; m_drdata = '0; m_streak = 0;
  endtask

  task automatic model_step();
    bit force_i;
    m_ival = 1'b0;
    m_dval = 1'b0;
    if (m_owner != 0) begin
      if (mem_ack) begin
        if (m_owner == 1) begin
          m_irdata = mem_rdata;
          m_ival   = 1'b1;
        end else begin
          if (!m_we) m_drdata = mem_rdata;
          m_dval = 1'b1;
        end
        m_owner = 0;
        m_resp  = 1'b1;
      end
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else begin
      force_i = 1'b0;
`ifdef ARB_ANTISTARVE_EN
      force_i = i_req && (m_streak == MAXS);
`endif
      if (d_req && !force_i) begin
        m_owner = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        m_be = d_we ? d_be : {BW{1'b1}};
        m_streak = i_req ? m_streak + 1 : 0;
      end else if (i_req) begin
        m_owner = 1; m_we = 1'b0; m_addr = i_addr; m_be = {BW{1'b1}};
        m_streak = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("mem_req", mem_req, (m_owner != 0));
    if (m_owner != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_be", mem_be, m_be);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("i_valid", i_valid, m_ival);
    chk("d_valid", d_valid, m_dval);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("stall_f", stall_f, i_req & ~m_ival);
    chk("stall_m", stall_m, d_req & ~m_dval);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  int d_before;
  bit fetch_seen;

  initial begin
    // Reset held with both requests asserted.
    i_req = 1'b1; d_req = 1'b1;
    repeat (3) begin
      step();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_valid", i_valid, 0);
      chk("rst_d_valid", d_valid, 0);
    end
    i_req = 1'b0; d_req = 1'b0; rst = 1'b1;
    step();

    // Fetch only, ack in the second mem_req cycle.
    i_req = 1'b1; i_addr = 32'h10;
    step();
    chk("fetch_req1", mem_req, 1);
    chk("fetch_addr", mem_addr, 32'h10);
    chk("fetch_be", mem_be, 4'hF);
    chk("fetch_we", mem_we, 0);
    step();
    chk("fetch_req2", mem_req, 1);
    chk("fetch_no_valid_yet", i_valid, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    step();
    chk("fetch_req_drop", mem_req, 0);
    chk("fetch_valid", i_valid, 1);
    chk("fetch_rdata", i_rdata, 32'h0050_0093);
    mem_ack = 1'b0; i_req = 1'b0;
    step();
    chk("fetch_valid_pulse", i_valid, 0);
    chk("fetch_rdata_held", i_rdata, 32'h0050_0093);

    // Collision: data wins, fetch stays stalled.
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'h0;
    step();
    chk("col_first_addr", mem_addr, 32'h100);
    chk("col_first_be", mem_be, 4'hF);
    chk("col_stall_f1", stall_f, 1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    chk("col_d_valid", d_valid, 1);
    chk("col_i_not_valid", i_valid, 0);
    chk("col_d_rdata", d_rdata, 32'h1111_2222);
    chk("col_stall_f2", stall_f, 1);
    mem_ack = 1'b0; d_req = 1'b0;
    step();
    chk("col_stall_f3", stall_f, 1);
    step();
    chk("col_second_addr", mem_addr, 32'h40);
    chk("col_stall_f4", stall_f, 1);
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    step();
    chk("col_i_valid", i_valid, 1);
    chk("col_i_rdata", i_rdata, 32'h3333_4444);
    chk("col_stall_f_clear", stall_f, 0);
    mem_ack = 1'b0; i_req = 1'b0;
    step();

    // Store: d_rdata must keep the previous load value.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("st_we", mem_we, 1);
    chk("st_be", mem_be, 4'b0011);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    chk("st_d_valid", d_valid, 1);
    chk("st_d_rdata_kept", d_rdata, 32'h1111_2222);
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    chk("st_d_valid_pulse", d_valid, 0);

    // Abort: reset while mem_req is high, late ack ignored.
    i_req = 1'b1; i_addr = 32'h80;
    step();
    chk("ab_req_up", mem_req, 1);
    rst = 1'b0; i_req = 1'b0;
    #1;
    chk("ab_req_async_drop", mem_req, 0);
    step();
    rst = 1'b1; mem_ack = 1'b1;
    repeat (3) begin
      step();
      chk("ab_no_i_valid", i_valid, 0);
      chk("ab_no_d_valid", d_valid, 0);
      chk("ab_no_mem_req", mem_req, 0);
    end
    mem_ack = 1'b0;

    // Back-to-back data with fetch waiting, ack every cycle.
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_ack = 1'b1;
    d_before = 0; fetch_seen = 1'b0;
    repeat (30) begin
      step();
      if (mem_req && mem_addr == 32'h300 && !fetch_seen) d_before++;
      if (mem_req && mem_addr == 32'h200) fetch_seen = 1'b1;
    end
`ifdef ARB_ANTISTARVE_EN
    chk("starve_fetch_granted", fetch_seen, 1);
    chk("starve_d_streak", d_before, MAXS);
`else
    chk("starve_no_fetch", fetch_seen, 0);
    chk("starve_d_grants", d_before, 10);
`endif
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) step();
    mem_ack = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      if (!i_req) begin
        if ($urandom_range(0, 1) == 1) begin
          i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
        end
      end else if (m_ival) begin
        if ($urandom_range(0, 1) == 1) i_req = 1'b0;
        else i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || m_dval) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
      end
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
